// File: rtl/propose_move_sequencer.sv
// Move sequencer feeding the corner-point proposer: streams clauses, pulses reduce
// enables, waits out the proposer latency and commits the saturated result.
//
// state   | meaning
// IDLE    | accepts assignment loads and move starts
// LOAD    | streams clause coefficients (N issues + 1 drain cycle)
// REDUCE  | single cycle of per-clause reduce enables
// WAIT    | waits out the remaining proposer pipeline latency
// COMMIT  | samples, saturates and writes the proposed value
module propose_move_sequencer #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 4,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3,
  parameter int PROPOSE_LATENCY                     = 2,
  localparam int CW = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT,
  localparam int VI = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX,
  localparam int IW = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE,
  localparam int CI = MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int NV = 1 << VI,
  localparam int NC = 1 << CI
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic [VI-1:0]        in_variable_index,
  input  logic                 in_reload_clauses,
  input  logic [CI:0]          in_clause_count,
  input  logic                 in_load_assignment,
  input  logic [IW*NV-1:0]     in_initial_assignment,
  output logic                 out_clause_rd_en,
  output logic [CI-1:0]        out_clause_rd_addr,
  input  logic [(NV+1)*CW-1:0] in_clause_rd_data,
  output logic [(NV+1)*CW-1:0] out_clause_coefficients,
  output logic [CI-1:0]        out_clause_index,
  output logic                 out_clause_load_valid,
  output logic [NC-1:0]        out_reduce_enable,
  output logic [VI-1:0]        out_variable_index,
  output logic [IW*NV-1:0]     out_assignment,
  input  logic [CW-1:0]        in_new_assignment,
  output logic                 out_busy,
  output logic                 out_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_REDUCE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  // WAIT lasts PROPOSE_LATENCY-1 cycles; the down-counter is preset to one less.
  localparam int WAIT_PRESET = (PROPOSE_LATENCY >= 2) ? PROPOSE_LATENCY - 2 : 0;
  localparam int WW          = (PROPOSE_LATENCY > 2) ? $clog2(PROPOSE_LATENCY - 1) : 1;

  localparam int SAT_MAX_I = 2 ** (IW - 1) - 1;
  localparam int SAT_MIN_I = -(2 ** (IW - 1));
  localparam logic signed [CW-1:0] SAT_MAX = SAT_MAX_I[CW-1:0];
  localparam logic signed [CW-1:0] SAT_MIN = SAT_MIN_I[CW-1:0];
  localparam logic [CI:0] NC_COUNT = (CI + 1)'(NC);

  logic [2:0]       state;
  logic [VI-1:0]    var_idx;
  logic [CI:0]      count;
  logic [CI:0]      issue_cnt;
  logic [WW-1:0]    wait_cnt;
  logic             load_valid;
  logic [CI-1:0]    clause_index;
  logic [IW*NV-1:0] assignment;
  logic             done;

  logic             rd_en;
  logic [CI-1:0]    rd_addr;
  logic [CI:0]      start_count;
  logic [IW-1:0]    sat_val;
  logic [NC-1:0]    reduce_enable;

  // Counts above NC are clamped so the issue loop cannot run past clause memory.
  assign start_count = (in_clause_count > NC_COUNT) ? NC_COUNT : in_clause_count;

  assign rd_en   = (state == ST_LOAD) && (issue_cnt < count);
  assign rd_addr = rd_en ? issue_cnt[CI-1:0] : '0;

  always_comb begin
    sat_val = in_new_assignment[IW-1:0];
    if ($signed(in_new_assignment) > SAT_MAX)
      sat_val = SAT_MAX[IW-1:0];
    else if ($signed(in_new_assignment) < SAT_MIN)
      sat_val = SAT_MIN[IW-1:0];
  end

  always_comb begin
    reduce_enable = '0;
    if (state == ST_REDUCE) begin
      for (int k = 0; k < NC; k++)
        reduce_enable[k] = (k < int'(count));
    end
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state        <= ST_IDLE;
      var_idx      <= '0;
      count        <= '0;
      issue_cnt    <= '0;
      wait_cnt     <= '0;
      load_valid   <= 1'b0;
      clause_index <= '0;
      assignment   <= '0;
      done         <= 1'b0;
    end else begin
      done       <= 1'b0;
      load_valid <= rd_en;
      if (rd_en)
        clause_index <= rd_addr;
      case (state)
        ST_IDLE: begin
          if (in_load_assignment)
            assignment <= in_initial_assignment;
          if (in_start) begin
            var_idx   <= in_variable_index;
            count     <= start_count;
            issue_cnt <= '0;
            state     <= (in_reload_clauses && (start_count != '0)) ? ST_LOAD : ST_REDUCE;
          end
        end
        ST_LOAD: begin
          // issue_cnt == count marks the drain cycle for the last read.
          if (issue_cnt == count)
            state <= ST_REDUCE;
          else
            issue_cnt <= issue_cnt + 1'b1;
        end
        ST_REDUCE: begin
          wait_cnt <= WW'(WAIT_PRESET);
          state    <= (PROPOSE_LATENCY > 1) ? ST_WAIT : ST_COMMIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0)
            state <= ST_COMMIT;
          else
            wait_cnt <= wait_cnt - 1'b1;
        end
        ST_COMMIT: begin
          if (count != '0)
            assignment[var_idx*IW +: IW] <= sat_val;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_clause_rd_en        = rd_en;
  assign out_clause_rd_addr      = rd_addr;
  assign out_clause_load_valid   = load_valid;
  assign out_clause_index        = clause_index;
  // Gated so the proposer bus is quiet outside load beats.
  assign out_clause_coefficients = load_valid ? in_clause_rd_data : '0;
  assign out_reduce_enable       = reduce_enable;
  assign out_variable_index      = var_idx;
  assign out_assignment          = assignment;
  assign out_busy                = (state != ST_IDLE);
  assign out_done                = done;

endmodule
